// File: rtl/apb_req_master.sv
// APB requester: converts a valid/ready command stream into single APB transfers
// and returns read data, slave error and timeout status on a valid/ready response.
module apb_req_master #(
    parameter int APB_ADDR_WIDTH = 16,
    parameter int APB_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      pnreset,
    input  logic                      penable,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                      o_psel,
    output logic                      o_penable,
    output logic                      o_pwrite,
    output logic [APB_ADDR_WIDTH-1:0] o_paddr,
    output logic [APB_DATA_WIDTH-1:0] o_pwdata,
    input  logic                      i_pready,
    input  logic [APB_DATA_WIDTH-1:0] i_prdata,
    input  logic                      i_pslverr,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                      o_rsp_err,
    output logic                      o_rsp_timeout
);

    // A zero timeout still needs a 1-bit counter so the declarations stay legal.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      write_q, write_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      psel_q, psel_d;
    logic                      pen_q, pen_d;
    logic                      rsp_valid_q, rsp_valid_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    write_d = i_cmd_write;
                    addr_d  = i_cmd_addr;
                    wdata_d = i_cmd_wdata;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready is checked first so it wins over a same-cycle timeout.
                if (i_pready) begin
                    rsp_rdata_d   = write_q ? '0 : i_prdata;
                    rsp_err_d     = i_pslverr;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered with it.
        cmd_ready_d = (state_d == ST_IDLE);
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        pen_d       = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge pclk) begin
        if (!pnreset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            pen_q         <= 1'b0;
            rsp_valid_q   <= 1'b0;
        end else if (penable) begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            pen_q         <= pen_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    assign o_cmd_ready   = cmd_ready_q;
    assign o_psel        = psel_q;
    assign o_penable     = pen_q;
    assign o_pwrite      = write_q;
    assign o_paddr       = addr_q;
    assign o_pwdata      = wdata_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed plus randomized bench for apb_req_master; expectations come from a
// transfer-level model (wait count vs. timeout budget), not from the FSM.
module tb_apb_req_master;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 16;
    localparam int NEVER = 1000;

    logic          pclk = 1'b0;
    logic          pnreset;
    logic          penable;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_write;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wdata;
    logic          o_psel;
    logic          o_penable;
    logic          o_pwrite;
    logic [AW-1:0] o_paddr;
    logic [DW-1:0] o_pwdata;
    logic          i_pready;
    logic [DW-1:0] i_prdata;
    logic          i_pslverr;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_err;
    logic          o_rsp_timeout;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_req_master #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .pnreset(pnreset), .penable(penable),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
        .o_paddr(o_paddr), .o_pwdata(o_pwdata),
        .i_pready(i_pready), .i_prdata(i_prdata), .i_pslverr(i_pslverr),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic junk_slave();
        i_prdata  = DW'($urandom);
        i_pslverr = 1'($urandom);
    endtask

    // One transfer; 'waits' = pready-low ACCESS cycles the slave inserts.
    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdat, input int waits, input bit slv,
                        input int hold, input bit freeze);
        int acc;
        bit exp_to;
        int exp_acc;
        logic [DW-1:0] exp_rd;
        bit exp_err;
        exp_to  = (waits >= TO);
        exp_acc = exp_to ? TO : waits + 1;
        exp_rd  = (exp_to || wr) ? '0 : rdat;
        exp_err = exp_to || slv;

        chk("idle_cmd_ready", o_cmd_ready, 1);
        i_cmd_valid = 1'b1;
        i_cmd_write = wr;
        i_cmd_addr  = addr;
        i_cmd_wdata = wdata;
        i_pready    = 1'b0;
        junk_slave();
        step();
        // Command bus scribbled outside IDLE must not leak into the transfer.
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'($urandom);
        i_cmd_addr  = AW'($urandom);
        i_cmd_wdata = DW'($urandom);
        chk("setup_phase", {o_psel, o_penable, o_cmd_ready, o_rsp_valid}, 4'b1000);
        chk("setup_pwrite", o_pwrite, wr);
        chk("setup_paddr", o_paddr, addr);
        chk("setup_pwdata", o_pwdata, wdata);
        if (freeze) begin
            penable = 1'b0;
            repeat (5) begin
                step();
                chk("freeze_setup", {o_psel, o_penable}, 2'b10);
            end
            penable = 1'b1;
        end
        step();
        acc = 0;
        while (o_psel && o_penable && acc < 100) begin
            acc++;
            chk("access_paddr", o_paddr, addr);
            chk("access_pwrite", o_pwrite, wr);
            chk("access_pwdata", o_pwdata, wdata);
            if (freeze && acc == 2) begin
                penable  = 1'b0;
                i_pready = 1'b1;
                repeat (5) begin
                    step();
                    chk("freeze_access", {o_psel, o_penable, o_rsp_valid}, 3'b110);
                end
                penable = 1'b1;
            end
            if (acc == waits + 1) begin
                i_pready  = 1'b1;
                i_prdata  = rdat;
                i_pslverr = slv;
            end else begin
                i_pready = 1'b0;
                junk_slave();
            end
            step();
        end
        i_pready    = 1'b0;
        i_cmd_valid = 1'b0;
        junk_slave();
        chk("access_cycles", acc, exp_acc);
        chk("resp_phase", {o_psel, o_penable, o_cmd_ready, o_rsp_valid}, 4'b0001);
        chk("rsp_rdata", o_rsp_rdata, exp_rd);
        chk("rsp_err", o_rsp_err, exp_err);
        chk("rsp_timeout", o_rsp_timeout, exp_to);
        repeat (hold) begin
            step();
            chk("hold_valid", {o_rsp_valid, o_cmd_ready, o_psel}, 3'b100);
            chk("hold_fields", {o_rsp_rdata, o_rsp_err, o_rsp_timeout}, {exp_rd, exp_err, exp_to});
        end
        i_rsp_ready = 1'b1;
        if (freeze) begin
            penable = 1'b0;
            repeat (2) begin
                step();
                chk("freeze_resp", {o_rsp_valid, o_cmd_ready}, 2'b10);
            end
            penable = 1'b1;
        end
        step();
        i_rsp_ready = 1'b0;
        chk("after_rsp", {o_rsp_valid, o_cmd_ready, o_psel}, 3'b010);
    endtask

    initial begin
        int waits_tab[8];
        waits_tab = '{0, 1, 3, 14, 15, 16, NEVER, 2};
        pnreset = 1'b0; penable = 1'b1;
        i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
        i_pready = 1'b0; i_prdata = '0; i_pslverr = 1'b0; i_rsp_ready = 1'b0;
        step();
        step();
        chk("reset_ctrl", {o_cmd_ready, o_psel, o_penable, o_rsp_valid}, 4'b1000);
        chk("reset_bus", {o_pwrite, o_paddr, o_pwdata}, '0);
        chk("reset_rsp", {o_rsp_rdata, o_rsp_err, o_rsp_timeout}, '0);
        pnreset = 1'b1;
        step();

        xfer(1'b1, 16'h0001, 16'hA5A5, 16'h0000, 0, 1'b0, 0, 1'b0);
        xfer(1'b0, 16'h0000, 16'h0000, 16'h1234, 3, 1'b0, 1, 1'b0);
        xfer(1'b0, 16'h0042, 16'h0000, 16'hBEEF, NEVER, 1'b0, 0, 1'b0);
        xfer(1'b0, 16'h0043, 16'h0000, 16'h5A5A, 0, 1'b1, 0, 1'b0);
        xfer(1'b0, 16'h0044, 16'h0000, 16'hC0DE, 15, 1'b0, 0, 1'b0);
        xfer(1'b1, 16'h0100, 16'h7E57, 16'h0000, 3, 1'b0, 10, 1'b1);

        // Reset in the middle of ACCESS: transfer vanishes, no response.
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 16'h0F0F;
        step();
        i_cmd_valid = 1'b0;
        step();
        step();
        chk("pre_reset_access", {o_psel, o_penable}, 2'b11);
        pnreset = 1'b0;
        step();
        chk("mid_reset", {o_psel, o_penable, o_rsp_valid, o_cmd_ready}, 4'b0001);
        pnreset = 1'b1;
        step();
        chk("post_reset_idle", {o_psel, o_rsp_valid, o_cmd_ready}, 3'b001);
        xfer(1'b1, 16'h0002, 16'h3C3C, 16'h0000, 1, 1'b0, 0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            xfer(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                 waits_tab[$urandom_range(0, 7)], 1'($urandom), $urandom_range(0, 3),
                 ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
